// File: rtl/wb_pkg.sv
// Shared definitions for the PicoRV32-to-Wishbone classic bridge.
// Holds the FSM state encoding and the fixed bus constants.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } wb_state_e;

  localparam logic [31:0] WB_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [3:0]  WB_SEL_WORD = 4'hF;

endpackage

// File: rtl/wb_master_if.sv
// Wishbone classic bus bundle between the bridge (master) and a slave.
interface wb_master_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_wb_sel,
    input  i_wb_data, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data, o_wb_sel,
    output i_wb_data, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/wb_master.sv
// PicoRV32 native memory port to Wishbone classic master, one transfer at a time,
// with a bounded wait for ack/err and a sticky bus-error flag.
module wb_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  wb_master_if.master       wb,
  output logic              o_bus_err,
  input  logic              i_err_clr
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e        r_state, w_state;
  logic             r_cyc, w_cyc;
  logic             r_we, w_we;
  logic [31:0]      r_adr, w_adr;
  logic [31:0]      r_data, w_data;
  logic [3:0]       r_sel, w_sel;
  logic             r_ready, w_ready;
  logic [31:0]      r_rdata, w_rdata;
  logic             r_bus_err, w_bus_err;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             w_err_set;

  // Next-state and next-output logic; every register holds unless a branch says otherwise.
  always_comb begin
    w_state   = r_state;
    w_cyc     = r_cyc;
    w_we      = r_we;
    w_adr     = r_adr;
    w_data    = r_data;
    w_sel     = r_sel;
    w_ready   = 1'b0;
    w_rdata   = r_rdata;
    w_cnt     = r_cnt;
    w_err_set = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_state = ST_BUS;
          w_cyc   = 1'b1;
          w_adr   = mem_addr;
          w_data  = mem_wdata;
          w_we    = |mem_wstrb;
          w_sel   = (|mem_wstrb) ? mem_wstrb : WB_SEL_WORD;
          w_cnt   = '0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_BUS: begin
        // err outranks ack; both outrank the timeout in the same cycle
        if (wb.i_wb_err || (!wb.i_wb_ack && (r_cnt == CNT_LAST))) begin
          w_state   = ST_DONE;
          w_cyc     = 1'b0;
          w_ready   = 1'b1;
          w_rdata   = WB_ALL_ONES;
          w_err_set = 1'b1;
        end else if (wb.i_wb_ack) begin
          w_state = ST_DONE;
          w_cyc   = 1'b0;
          w_ready = 1'b1;
          w_rdata = r_we ? r_rdata : wb.i_wb_data;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_cyc   = 1'b0;
      end
    endcase

    if (w_err_set) begin
      w_bus_err = 1'b1;
    end else if (i_err_clr) begin
      w_bus_err = 1'b0;
    end else begin
      w_bus_err = r_bus_err;
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= 32'h0000_0000;
      r_data    <= 32'h0000_0000;
      r_sel     <= 4'h0;
      r_ready   <= 1'b0;
      r_rdata   <= 32'h0000_0000;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_cyc     <= w_cyc;
      r_we      <= w_we;
      r_adr     <= w_adr;
      r_data    <= w_data;
      r_sel     <= w_sel;
      r_ready   <= w_ready;
      r_rdata   <= w_rdata;
      r_bus_err <= w_bus_err;
      r_cnt     <= w_cnt;
    end
  end

  // stb shares the cyc register so it can never be high on its own
  assign wb.o_wb_cyc  = r_cyc;
  assign wb.o_wb_stb  = r_cyc;
  assign wb.o_wb_we   = r_we;
  assign wb.o_wb_adr  = r_adr;
  assign wb.o_wb_data = r_data;
  assign wb.o_wb_sel  = r_sel;
  assign mem_ready    = r_ready;
  assign mem_rdata    = r_rdata;
  assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: reads, waited write, timeout, ack+err, reset abort, held mem_valid.
module tb_wb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        o_bus_err;
  logic        i_err_clr;

  logic        ack_en;
  logic        err_en;
  int          ack_wait;
  int          stb_cnt;
  logic [31:0] slave_data;

  int checks = 0;
  int errors = 0;

  int ready_cnt  = 0;
  int dbl_ready  = 0;
  int cyc_rise   = 0;
  int stb_wo_cyc = 0;
  logic prev_ready = 1'b0;
  logic prev_cyc   = 1'b0;

  wb_master_if wb ();

  wb_master #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wb        (wb),
    .o_bus_err (o_bus_err),
    .i_err_clr (i_err_clr)
  );

  always #5 clk = ~clk;

  // Slave model: ack after ack_wait cycles of stb, optional err, fixed read data.
  always @(posedge clk) stb_cnt <= wb.o_wb_stb ? stb_cnt + 1 : 0;
  assign wb.i_wb_ack  = wb.o_wb_stb & ack_en & (stb_cnt >= ack_wait);
  assign wb.i_wb_err  = wb.o_wb_stb & err_en;
  assign wb.i_wb_data = slave_data;

  // Protocol monitor on the inactive edge.
  always @(negedge clk) begin
    if (mem_ready) begin
      ready_cnt++;
      if (prev_ready) dbl_ready++;
    end
    prev_ready = mem_ready;
    if (wb.o_wb_cyc && !prev_cyc) cyc_rise++;
    prev_cyc = wb.o_wb_cyc;
    if (wb.o_wb_stb && !wb.o_wb_cyc) stb_wo_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int r0;
    int c0;

    stb_cnt    = 0;
    rst_n      = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_wstrb  = 4'h0;
    i_err_clr  = 1'b0;
    ack_en     = 1'b1;
    err_en     = 1'b0;
    ack_wait   = 0;
    slave_data = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1;
    chk1 ("rst_cyc",   wb.o_wb_cyc, 1'b0);
    chk1 ("rst_stb",   wb.o_wb_stb, 1'b0);
    chk1 ("rst_ready", mem_ready,   1'b0);
    chk32("rst_rdata", mem_rdata,   32'h0);
    chk32("rst_adr",   wb.o_wb_adr, 32'h0);
    chk32("rst_sel",   {28'h0, wb.o_wb_sel}, 32'h0);
    chk1 ("rst_err",   o_bus_err,   1'b0);
    rst_n = 1'b1;

    // Read with combinational ack.
    mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
    step();
    chk1 ("rd_cyc",   wb.o_wb_cyc, 1'b1);
    chk1 ("rd_stb",   wb.o_wb_stb, 1'b1);
    chk1 ("rd_we",    wb.o_wb_we,  1'b0);
    chk32("rd_sel",   {28'h0, wb.o_wb_sel}, 32'h0000_000F);
    chk32("rd_adr",   wb.o_wb_adr, 32'h0000_0100);
    chk1 ("rd_ready_early", mem_ready, 1'b0);
    step();
    chk1 ("rd_ready", mem_ready,   1'b1);
    chk1 ("rd_cyc_drop", wb.o_wb_cyc, 1'b0);
    chk32("rd_rdata", mem_rdata,   32'hDEAD_BEEF);
    mem_valid = 1'b0;
    step();
    chk1 ("rd_ready_pulse", mem_ready, 1'b0);
    step();

    // Write with three wait states.
    r0 = ready_cnt;
    ack_wait = 3;
    mem_valid = 1'b1; mem_addr = 32'h0200_0000; mem_wdata = 32'h0000_1234; mem_wstrb = 4'b0011;
    step();
    for (int i = 0; i < 4; i++) begin
      chk1 ("wr_cyc",  wb.o_wb_cyc, 1'b1);
      chk1 ("wr_we",   wb.o_wb_we,  1'b1);
      chk32("wr_adr",  wb.o_wb_adr, 32'h0200_0000);
      chk32("wr_data", wb.o_wb_data, 32'h0000_1234);
      chk32("wr_sel",  {28'h0, wb.o_wb_sel}, 32'h0000_0003);
      chk1 ("wr_ready_wait", mem_ready, 1'b0);
      step();
    end
    chk1 ("wr_ready", mem_ready, 1'b1);
    chk1 ("wr_cyc_drop", wb.o_wb_cyc, 1'b0);
    chk32("wr_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    step();
    step();
    chk32("wr_ready_count", 32'(ready_cnt - r0), 32'd1);

    // Timeout: slave never responds.
    ack_en = 1'b0; ack_wait = 0;
    mem_valid = 1'b1; mem_addr = 32'h0000_0300;
    step();
    n = 0;
    while (wb.o_wb_cyc && n < 20) begin
      n++;
      step();
    end
    chk32("to_cycles", 32'(n), 32'd8);
    chk1 ("to_ready",  mem_ready, 1'b1);
    chk32("to_rdata",  mem_rdata, 32'hFFFF_FFFF);
    chk1 ("to_err",    o_bus_err, 1'b1);
    mem_valid = 1'b0;
    step();
    step();
    chk1 ("to_err_sticky", o_bus_err, 1'b1);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk1 ("to_err_clr", o_bus_err, 1'b0);

    // ack and err together, with a clear pulse landing on the same edge.
    r0 = ready_cnt;
    ack_en = 1'b1; err_en = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h0000_0400;
    step();
    chk1 ("ae_cyc", wb.o_wb_cyc, 1'b1);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk1 ("ae_ready", mem_ready, 1'b1);
    chk32("ae_rdata", mem_rdata, 32'hFFFF_FFFF);
    chk1 ("ae_err_set_wins", o_bus_err, 1'b1);
    mem_valid = 1'b0; err_en = 1'b0;
    step();
    chk1 ("ae_ready_pulse", mem_ready, 1'b0);
    step();
    chk32("ae_ready_count", 32'(ready_cnt - r0), 32'd1);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk1 ("ae_err_clr", o_bus_err, 1'b0);

    // Reset in the middle of a waited cycle.
    r0 = ready_cnt;
    ack_en = 1'b0;
    slave_data = 32'h1357_9BDF;
    mem_valid = 1'b1; mem_addr = 32'h0000_0500;
    step();
    chk1 ("rb_cyc", wb.o_wb_cyc, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk1 ("rb_cyc_async", wb.o_wb_cyc, 1'b0);
    chk1 ("rb_stb_async", wb.o_wb_stb, 1'b0);
    chk32("rb_adr_async", wb.o_wb_adr, 32'h0);
    step();
    ack_en = 1'b1;
    rst_n = 1'b1;
    chk32("rb_no_ready", 32'(ready_cnt - r0), 32'd0);
    step();
    chk1 ("rb_new_cyc", wb.o_wb_cyc, 1'b1);
    step();
    chk1 ("rb_new_ready", mem_ready, 1'b1);
    chk32("rb_new_rdata", mem_rdata, 32'h1357_9BDF);
    mem_valid = 1'b0;
    step();
    step();

    // mem_valid held for three cycles after mem_ready.
    r0 = ready_cnt;
    c0 = cyc_rise;
    mem_valid = 1'b1; mem_addr = 32'h0000_0600;
    step();
    step();
    chk1 ("hv_ready", mem_ready, 1'b1);
    step();
    chk1 ("hv_done_no_cyc", wb.o_wb_cyc, 1'b0);
    step();
    chk1 ("hv_reissue_cyc", wb.o_wb_cyc, 1'b1);
    mem_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk32("hv_cyc_count",   32'(cyc_rise - c0),  32'd2);
    chk32("hv_ready_count", 32'(ready_cnt - r0), 32'd2);
    chk1 ("hv_idle", wb.o_wb_cyc, 1'b0);

    chk32("mon_double_ready", 32'(dbl_ready),  32'd0);
    chk32("mon_stb_wo_cyc",   32'(stb_wo_cyc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
